// File: rtl/rmii_tx_serializer_if.sv
// rmii_tx_serializer_if
//   Byte stream in, RMII dibit stream out, for rmii_tx_serializer.
//   Handshake: a byte moves on a rising clk edge where s_valid and s_ready
//   are both high. s_ready depends only on the serializer's own state, so
//   the source may look at it before it decides on s_valid. s_data and
//   s_last are don't-care whenever s_ready is low.
//   Signals:
//     s_valid  upstream byte valid
//     s_data   frame byte, sent LSB dibit first
//     s_last   marks the final byte of the frame, taken with s_data
//     s_ready  serializer can take a byte this cycle
//     txd      RMII transmit dibit (registered)
//     tx_en    RMII transmit enable (registered)
//     underrun one-cycle pulse when the source starves mid-frame
//     busy     serializer is anywhere but idle
//   Modports: master = byte source, slave = serializer.
interface rmii_tx_serializer_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic [1:0] txd;
  logic       tx_en;
  logic       underrun;
  logic       busy;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, txd, tx_en, underrun, busy
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, txd, tx_en, underrun, busy
  );
endinterface

// File: rtl/rmii_tx_serializer.sv
// rmii_tx_serializer
//   Turns a byte stream into RMII transmit dibits. Each frame gets a
//   7-byte preamble, then the 0xD5 start delimiter, then the payload bytes
//   (LSB dibit first), then a 48-cycle inter-frame gap.
//   Ports:
//     clk          RMII reference clock, one dibit per cycle
//     rst          synchronous, active-high reset
//     bus          rmii_tx_serializer_if.slave (byte input, RMII output)
//     dbg_state_o  current FSM state, for debug visibility
module rmii_tx_serializer (
  input  logic                       clk,
  input  logic                       rst,
  rmii_tx_serializer_if.slave        bus,
  output logic [2:0]                 dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    DATA     = 3'd3,
    IFG      = 3'd4
  } state_t;

  localparam logic [5:0] PREAMBLE_LAST = 6'd27; // 28 cycles
  localparam logic [5:0] IFG_LAST      = 6'd47; // 48 cycles

  state_t     state_q, state_d;
  logic [1:0] dibit_q, dibit_d;
  logic [5:0] cyc_q, cyc_d;
  logic [7:0] shift_q, shift_d;
  logic       last_q, last_d;
  logic [1:0] txd_q, txd_d;
  logic       tx_en_q, tx_en_d;
  logic       underrun_q, underrun_d;

  logic ready;
  logic take;
  logic starve;

  // A byte slot opens on the final dibit of SFD and on the final dibit of
  // every payload byte that is not the frame's last one.
  assign ready  = !rst && (dibit_q == 2'd3) &&
                  ((state_q == SFD) || ((state_q == DATA) && !last_q));
  assign take   = ready && bus.s_valid;
  assign starve = ready && !bus.s_valid;

  always_comb begin
    state_d    = state_q;
    dibit_d    = (state_q == IDLE) ? 2'd0 : dibit_q + 2'd1;
    cyc_d      = '0;
    shift_d    = shift_q;
    last_d     = last_q;
    underrun_d = starve;

    case (state_q)
      IDLE: begin
        if (bus.s_valid) state_d = PREAMBLE;
      end
      PREAMBLE: begin
        if (cyc_q == PREAMBLE_LAST) state_d = SFD;
        else                        cyc_d   = cyc_q + 6'd1;
      end
      SFD: begin
        if (dibit_q == 2'd3) state_d = take ? DATA : IFG;
      end
      DATA: begin
        shift_d = {2'b00, shift_q[7:2]};
        if (dibit_q == 2'd3 && (last_q || starve)) state_d = IFG;
      end
      IFG: begin
        if (cyc_q == IFG_LAST) state_d = IDLE;
        else                   cyc_d   = cyc_q + 6'd1;
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      shift_d = bus.s_data;
      last_d  = bus.s_last;
    end

    // Outputs are registered from the next state, so the line shows exactly
    // what the state being entered stands for, with no extra cycle of lag.
    tx_en_d = (state_d == PREAMBLE) || (state_d == SFD) || (state_d == DATA);
    case (state_d)
      PREAMBLE: txd_d = 2'b01;
      SFD:      txd_d = (dibit_d == 2'd3) ? 2'b11 : 2'b01;
      DATA:     txd_d = shift_d[1:0];
      default:  txd_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dibit_q    <= 2'd0;
      cyc_q      <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      txd_q      <= 2'b00;
      tx_en_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dibit_q    <= dibit_d;
      cyc_q      <= cyc_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.s_ready  = ready;
  assign bus.txd      = txd_q;
  assign bus.tx_en    = tx_en_q;
  assign bus.underrun = underrun_q;
  assign bus.busy     = (state_q != IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_rmii_tx_serializer.sv
module tb_rmii_tx_serializer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rmii_tx_serializer_if bus ();

  rmii_tx_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] frame_q[$];
  // per-cycle expectation: {busy, tx_en, txd[1:0], s_ready, underrun}
  logic [5:0] exp_q[$];
  int hi_cnt;
  int first_hi;
  int last_hi;

  // Frame-level model: preamble, SFD, the bytes actually sent, then the gap.
  task automatic build_expected(input int n, input int drop_at);
    int nsent;
    logic [7:0] by;
    logic [1:0] dib;
    nsent = (drop_at < 0) ? n : drop_at;
    exp_q.delete();
    for (int i = 0; i < 28; i++) exp_q.push_back({1'b1, 1'b1, 2'b01, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++)
      exp_q.push_back({1'b1, 1'b1, (i == 3) ? 2'b11 : 2'b01, (i == 3), 1'b0});
    for (int b = 0; b < nsent; b++) begin
      by = frame_q[b];
      for (int j = 0; j < 4; j++) begin
        dib = by[2*j +: 2];
        exp_q.push_back({1'b1, 1'b1, dib, (j == 3) && (b < n - 1), 1'b0});
      end
    end
    for (int i = 0; i < 48; i++)
      exp_q.push_back({1'b1, 1'b0, 2'b00, 1'b0, (i == 0) && (drop_at >= 0)});
  endtask

  // Starts from an IDLE DUT at a negedge; runs one frame through its gap
  // and the following IDLE cycle. drop_at = byte slot where the source
  // starves (-1 = never). noise randomizes s_valid/s_data while not ready.
  task automatic run_frame(input int drop_at, input bit noise);
    int n;
    int idx;
    int len;
    logic [5:0] got;
    n = frame_q.size();
    idx = 0;
    hi_cnt = 0;
    first_hi = -1;
    last_hi = -1;
    build_expected(n, drop_at);
    len = exp_q.size();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'($urandom);
    bus.s_last  = 1'($urandom);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      got = {bus.busy, bus.tx_en, bus.txd, bus.s_ready, bus.underrun};
      total++;
      if (got !== exp_q[k-1]) begin
        bad++;
        $display("FAIL frame_cycle %0d (bytes=%0d drop=%0d): got=%b exp=%b",
                 k - 1, n, drop_at, got, exp_q[k-1]);
      end
      if (bus.tx_en) begin
        hi_cnt++;
        last_hi = cyc;
        if (first_hi < 0) first_hi = cyc;
      end
      if (k == len) begin
        bus.s_valid = 1'b0;
      end else if (bus.s_ready) begin
        if (idx == drop_at || idx >= n) begin
          bus.s_valid = 1'b0;
          bus.s_data  = 8'($urandom);
          bus.s_last  = 1'($urandom);
        end else begin
          bus.s_valid = 1'b1;
          bus.s_data  = frame_q[idx];
          bus.s_last  = (idx == n - 1);
          idx++;
        end
      end else begin
        bus.s_valid = noise ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.s_data  = 8'($urandom);
        bus.s_last  = 1'($urandom);
      end
    end
    @(negedge clk);
    got = {bus.busy, bus.tx_en, bus.txd, bus.s_ready, bus.underrun};
    total++;
    if (got !== 6'b0) begin
      bad++;
      $display("FAIL idle_after_gap: got=%b exp=%b", got, 6'b0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [5:0] got;
    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 8'hFF;
    bus.s_last = 1'b0;
    repeat (3) @(negedge clk);
    got = {bus.busy, bus.tx_en, bus.txd, bus.s_ready, bus.underrun};
    total++;
    if (got !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got=%b exp=%b", got, 6'b0);
    end
    bus.s_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    got = {bus.busy, bus.tx_en, bus.txd, bus.s_ready, bus.underrun};
    total++;
    if (got !== 6'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got=%b exp=%b", got, 6'b0);
    end
  endtask

  task automatic test_single_byte;
    frame_q = '{8'hA5};
    run_frame(-1, 1'b0);
    total++;
    if (hi_cnt !== 36) begin
      bad++;
      $display("FAIL single_txen_len: got=%0d exp=%0d", hi_cnt, 36);
    end
  endtask

  task automatic test_three_byte;
    frame_q = '{8'h00, 8'hFF, 8'h3C};
    run_frame(-1, 1'b0);
    total++;
    if (hi_cnt !== 44) begin
      bad++;
      $display("FAIL three_txen_len: got=%0d exp=%0d", hi_cnt, 44);
    end
  endtask

  task automatic test_underrun;
    frame_q = '{8'h12, 8'h34, 8'h56};
    run_frame(1, 1'b0);
    frame_q = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_frame(2, 1'b1);
    frame_q = '{8'h77};
    run_frame(0, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [5:0] got;
    bus.s_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if ({bus.tx_en, bus.txd} !== 3'b101) begin
        bad++;
        $display("FAIL mid_preamble %0d: got=%b exp=%b", k, {bus.tx_en, bus.txd}, 3'b101);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    got = {bus.busy, bus.tx_en, bus.txd, bus.s_ready, bus.underrun};
    total++;
    if (got !== 6'b0) begin
      bad++;
      $display("FAIL mid_reset_abort: got=%b exp=%b", got, 6'b0);
    end
    rst = 1'b0;
    frame_q = '{8'hC3};
    run_frame(-1, 1'b0);
  endtask

  task automatic test_back_to_back;
    int a_last;
    frame_q = '{8'h5A, 8'h81};
    run_frame(-1, 1'b0);
    a_last = last_hi;
    frame_q = '{8'hE7};
    run_frame(-1, 1'b0);
    total++;
    if (first_hi - a_last !== 50) begin
      bad++;
      $display("FAIL back_to_back_gap: got=%0d exp=%0d", first_hi - a_last, 50);
    end
  endtask

  task automatic test_noise;
    frame_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame(-1, 1'b1);
  endtask

  task automatic test_random;
    int n;
    int drop;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 6);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
      drop = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      run_frame(drop, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    bus.s_last = 1'b0;
    test_reset();
    test_single_byte();
    test_three_byte();
    test_underrun();
    test_reset_mid();
    test_back_to_back();
    test_noise();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rmii_tx_serializer.md
RMII_TX_SERIALIZER -- requirements
Module: rmii_tx_serializer

Interface
REQ-001: clk  input  1  -- RMII reference clock; one dibit per cycle; all logic on posedge clk.
REQ-002: rst  input  1  -- reset, synchronous, active-high.
REQ-003: s_valid  input  1  -- upstream byte valid.
REQ-004: s_data  input  8  -- frame byte, sent LSB dibit first.
REQ-005: s_last  input  1  -- marks the final byte of the frame; sampled with s_data.
REQ-006: s_ready  output  1  -- combinational; a byte transfers on a cycle where s_valid and s_ready are both high.
REQ-007: txd  output  2  -- registered RMII transmit dibit.
REQ-008: tx_en  output  1  -- registered RMII transmit enable.
REQ-009: underrun  output  1  -- registered one-cycle pulse when upstream starves mid-frame.
REQ-010: busy  output  1  -- high in every state except IDLE.

Function
REQ-011: The FSM SHALL have the states IDLE, PREAMBLE, SFD, DATA and IFG.
REQ-012: A 2-bit dibit counter SHALL count 0..3 and wrap to 0; it SHALL be held at 0 in IDLE.
REQ-013: In IDLE with s_valid=1, the next state SHALL be PREAMBLE; no byte is consumed and s_ready=0.
REQ-014: PREAMBLE SHALL last 7 bytes (28 cycles) with txd=2'b01 and tx_en=1; a 5-bit cycle counter covers it, then the FSM moves to SFD.
REQ-015: SFD SHALL send 0xD5 LSB-first as txd 01,01,01,11 over 4 cycles, with tx_en=1.
REQ-016: s_ready SHALL be 1 only when dibit counter=3 and either state=SFD, or state=DATA with the held byte not flagged last.
REQ-017: On a transfer, the byte and its last flag SHALL load into the shift register; DATA then sends txd = byte[1:0], [3:2], [5:4], [7:6] on consecutive cycles.
REQ-018: Latency: the first data dibit SHALL appear on txd 33 cycles after the IDLE cycle that saw s_valid=1 (28 preamble + 4 SFD + 1 register stage).
REQ-019: After the 4th dibit of a byte flagged last, the FSM SHALL enter IFG and tx_en SHALL fall on the next cycle.
REQ-020: Underrun: if s_ready=1 and s_valid=0, then
  - underrun SHALL pulse for 1 cycle;
  - the FSM SHALL enter IFG and tx_en SHALL fall on the next cycle;
  - no further byte of the frame is accepted.
REQ-021: IFG SHALL hold tx_en=0 and txd=00 for 48 cycles, then enter IDLE; s_valid SHALL be ignored during IFG.
REQ-022: tx_en=0 SHALL always be accompanied by txd=00.
REQ-023: Back-to-back frames SHALL be separated by exactly 48 tx_en-low cycles plus the single IDLE detect cycle.
REQ-024: s_data and s_last SHALL be ignored whenever s_ready=0.

Reset
REQ-025: While rst=1, the block SHALL set state=IDLE, clear all counters, and drive txd=00, tx_en=0, underrun=0, busy=0, s_ready=0.
REQ-026: rst asserted mid-frame SHALL force tx_en=0 on the next edge with no IFG; once rst=0, a new frame SHALL be accepted immediately.

Verification
REQ-027: Single byte 0xA5 with s_last=1 -> 28 dibits of 01, then 01,01,01,11, then 01,01,10,10, then 48 cycles with tx_en=0; underrun never pulses.
REQ-028: 3-byte frame 0x00,0xFF,0x3C with s_valid always high -> s_ready high exactly 3 cycles, 4 apart; dibits 00x4, 11x4, 00,11,11,00; tx_en high for 44 cycles.
REQ-029: s_valid dropped at the 2nd data-byte boundary -> underrun=1 for 1 cycle, tx_en falls next cycle, IFG of 48 cycles, then busy=0.
REQ-030: rst pulsed at the 10th preamble cycle -> tx_en=0 on the next edge; s_valid held high gives a fresh 28-cycle preamble.
REQ-031: Two frames queued back-to-back -> the second preamble starts 50 cycles after the first frame's last tx_en-high cycle.
REQ-032: s_valid toggled randomly during IFG and PREAMBLE -> s_ready stays 0 and the output dibit stream is unaffected.
